// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
// Top-level game sequencer sitting downstream of the game logic. Walks through
// title, clear (game reset), play, win and lose phases; keeps the game logic in
// reset outside of play, gates the fire button into the game and tells the
// renderer which screen to draw. All outputs are registered and decoded from
// the next state, so they line up with the state register.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   click        in   fire/start button level (already synchronised)
//   base1_nuked  in   base 1 destroyed flag
//   base2_nuked  in   base 2 destroyed flag
//   base3_nuked  in   base 3 destroyed flag
//   killcount    in   running kill total from the game logic
//   game_rst     out  reset to the game logic (high outside play)
//   playing      out  high in play only
//   screen       out  0 title/clear, 1 play, 2 win, 3 lose
//   bases_alive  out  number of bases not yet nuked
//   score        out  killcount frozen when play ends
//   click_game   out  click forwarded to the game logic
// -----------------------------------------------------------------------------
module game_state_ctrl #(
   parameter int OUT_WIDTH       = 8,
   parameter int KILLS_TO_WIN    = 20,
   parameter int CLEAR_CYCLES    = 16,
   parameter int END_SCREEN_TIME = 200_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 click,
   input  logic                 base1_nuked,
   input  logic                 base2_nuked,
   input  logic                 base3_nuked,
   input  logic [OUT_WIDTH-1:0] killcount,
   output logic                 game_rst,
   output logic                 playing,
   output logic [1:0]           screen,
   output logic [1:0]           bases_alive,
   output logic [OUT_WIDTH-1:0] score,
   output logic                 click_game
);

   localparam int CW = $clog2(CLEAR_CYCLES) + 1;
   localparam int TW = $clog2(END_SCREEN_TIME) + 1;
   localparam logic [CW-1:0]        CLR_LAST = CW'(CLEAR_CYCLES - 1);
   localparam logic [TW-1:0]        TMR_END  = TW'(END_SCREEN_TIME);
   localparam logic [OUT_WIDTH-1:0] KILLS    = OUT_WIDTH'(KILLS_TO_WIN);

   typedef enum logic [2:0] {
      ST_TITLE, ST_CLEAR, ST_PLAY, ST_WIN, ST_LOSE
   } state_t;

   state_t                 state_q, state_d;
   logic                   click_q;
   logic [2:0]             nuked_q, nuked_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic                   arm_q, arm_d;
   logic [OUT_WIDTH-1:0]   score_q, score_d;
   logic                   game_rst_q, playing_q, click_game_q;
   logic [1:0]             screen_q, bases_q;

   logic                   click_rise;
   logic [1:0]             dead;
   logic [1:0]             screen_d;

   assign click_rise = click & ~click_q;

   always_comb begin
      state_d = state_q;
      nuked_d = nuked_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      arm_d   = arm_q;
      score_d = score_q;

      case (state_q)
         ST_TITLE: if (click_rise) state_d = ST_CLEAR;
         ST_CLEAR: begin
            if (cnt_q == CLR_LAST) state_d = ST_PLAY;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_PLAY: begin
            nuked_d = nuked_q | {base3_nuked, base2_nuked, base1_nuked};
            // Arm only once the button has been seen released in play.
            if (!click) arm_d = 1'b1;
            if (&nuked_d)                state_d = ST_LOSE;
            else if (killcount >= KILLS) state_d = ST_WIN;
         end
         ST_WIN, ST_LOSE: begin
            // Timer saturates at the end value; clicks only count after that.
            if (tmr_q != TMR_END)    tmr_d   = tmr_q + 1'b1;
            else if (click_rise)     state_d = ST_CLEAR;
         end
         default: state_d = ST_TITLE;
      endcase

      if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
         cnt_d   = '0;
         nuked_d = '0;
         arm_d   = 1'b0;
      end
      if (state_q == ST_PLAY && state_d != ST_PLAY) begin
         arm_d   = 1'b0;
         tmr_d   = '0;
         score_d = killcount;
      end
   end

   always_comb begin
      dead = {1'b0, nuked_d[0]} + {1'b0, nuked_d[1]} + {1'b0, nuked_d[2]};
      case (state_d)
         ST_PLAY: screen_d = 2'd1;
         ST_WIN:  screen_d = 2'd2;
         ST_LOSE: screen_d = 2'd3;
         default: screen_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_TITLE;
         click_q      <= 1'b0;
         nuked_q      <= '0;
         cnt_q        <= '0;
         tmr_q        <= '0;
         arm_q        <= 1'b0;
         score_q      <= '0;
         game_rst_q   <= 1'b1;
         playing_q    <= 1'b0;
         screen_q     <= 2'd0;
         bases_q      <= 2'd3;
         click_game_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         click_q      <= click;
         nuked_q      <= nuked_d;
         cnt_q        <= cnt_d;
         tmr_q        <= tmr_d;
         arm_q        <= arm_d;
         score_q      <= score_d;
         game_rst_q   <= (state_d != ST_PLAY);
         playing_q    <= (state_d == ST_PLAY);
         screen_q     <= screen_d;
         bases_q      <= 2'd3 - dead;
         click_game_q <= click & arm_d & (state_d == ST_PLAY);
      end
   end

   assign game_rst    = game_rst_q;
   assign playing     = playing_q;
   assign screen      = screen_q;
   assign bases_alive = bases_q;
   assign score       = score_q;
   assign click_game  = click_game_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

   localparam int OW = 8;
   localparam int KW = 5;
   localparam int CC = 4;
   localparam int ET = 10;
   localparam int TITLE = 0, CLR = 1, PLY = 2, WN = 3, LS = 4;

   logic          clk = 1'b0;
   logic          rst, click, b1, b2, b3;
   logic [OW-1:0] kc;
   logic          game_rst, playing, click_game;
   logic [1:0]    screen, bases_alive;
   logic [OW-1:0] score;

   int errors = 0;
   int checks = 0;

   game_state_ctrl #(.OUT_WIDTH(OW), .KILLS_TO_WIN(KW), .CLEAR_CYCLES(CC),
                     .END_SCREEN_TIME(ET)) dut (
      .clk(clk), .rst(rst), .click(click),
      .base1_nuked(b1), .base2_nuked(b2), .base3_nuked(b3),
      .killcount(kc), .game_rst(game_rst), .playing(playing),
      .screen(screen), .bases_alive(bases_alive), .score(score),
      .click_game(click_game));

   always #5 clk = ~clk;

   // Reference model: phase plus "edges spent in this phase".
   int       m_ph, m_cnt, m_score;
   bit [2:0] m_lat;
   bit       m_arm, m_prev, m_cg;

   task automatic model_reset();
      m_ph = TITLE; m_cnt = 0; m_score = 0; m_lat = 0;
      m_arm = 0; m_prev = 0; m_cg = 0;
   endtask

   task automatic model_step();
      bit rise;
      int nxt;
      rise = click && !m_prev;
      nxt  = m_ph;
      m_cg = 0;
      case (m_ph)
         TITLE: if (rise) nxt = CLR;
         CLR:   if (m_cnt + 1 == CC) nxt = PLY;
         PLY: begin
            m_lat = m_lat | {b3, b2, b1};
            if (!click) m_arm = 1;
            if (m_lat == 3'b111) nxt = LS;
            else if (int'(kc) >= KW) nxt = WN;
            if (nxt != PLY) begin m_score = int'(kc); m_arm = 0; end
            else m_cg = click && m_arm;
         end
         default: if (m_cnt >= ET && rise) nxt = CLR;
      endcase
      if (nxt == CLR && m_ph != CLR) begin m_lat = 0; m_arm = 0; end
      m_cnt  = (nxt == m_ph) ? m_cnt + 1 : 0;
      m_ph   = nxt;
      m_prev = click;
   endtask

   function automatic logic [14:0] obs();
      return {game_rst, playing, screen, bases_alive, score, click_game};
   endfunction

   function automatic logic [14:0] expv();
      logic [1:0] sc, ba;
      sc = (m_ph == PLY) ? 2'd1 : (m_ph == WN) ? 2'd2 : (m_ph == LS) ? 2'd3 : 2'd0;
      ba = 2'(3 - $countones(m_lat));
      return {m_ph != PLY, m_ph == PLY, sc, ba, 8'(m_score), m_cg};
   endfunction

   task automatic tick(input bit c, input bit [2:0] f, input int k);
      click = c; {b3, b2, b1} = f; kc = 8'(k);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; click = 0; {b3, b2, b1} = 3'b000; kc = '0;
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic go_play();
      do_reset();
      tick(1, 0, 0);
      repeat (CC) tick(0, 0, 0);
   endtask

   task automatic test_reset();
      logic [14:0] want;
      do_reset();
      want = {1'b1, 1'b0, 2'd0, 2'd3, 8'd0, 1'b0};
      checks++;
      if (obs() !== want) begin
         errors++; $display("FAIL reset_vals got=%h want=%h", obs(), want);
      end
   endtask

   task automatic test_start();
      do_reset();
      tick(1, 0, 0);
      for (int i = 0; i < CC; i++) begin
         checks++;
         if ({game_rst, playing, screen} !== 4'b1000) begin
            errors++; $display("FAIL clear_phase cyc=%0d got=%b want=1000", i, {game_rst, playing, screen});
         end
         tick(0, 0, 0);
      end
      checks++;
      if ({game_rst, playing, screen, bases_alive} !== 6'b01_0111) begin
         errors++; $display("FAIL play_entry got=%b want=010111", {game_rst, playing, screen, bases_alive});
      end
   endtask

   task automatic test_hold_click();
      bit [3:0] pat;
      bit [3:0] want;
      do_reset();
      tick(1, 0, 0);
      repeat (CC) tick(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({playing, click_game} !== 2'b10) begin
            errors++; $display("FAIL held_click cyc=%0d got=%b want=10", i, {playing, click_game});
         end
         tick(1, 0, 0);
      end
      pat  = 4'b0101;  // click per cycle, LSB first: 1,0,1,0
      want = 4'b0101;
      tick(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(pat[i], 0, 0);
         checks++;
         if (click_game !== want[i]) begin
            errors++; $display("FAIL click_fwd cyc=%0d got=%b want=%b", i, click_game, want[i]);
         end
      end
   endtask

   task automatic test_lose();
      go_play();
      tick(0, 3'b001, 3);
      checks++;
      if (bases_alive !== 2'd2) begin
         errors++; $display("FAIL bases_after_b1 got=%0d want=2", bases_alive);
      end
      tick(0, 3'b000, 3);
      tick(0, 3'b100, 3);
      checks++;
      if (bases_alive !== 2'd1) begin
         errors++; $display("FAIL bases_after_b3 got=%0d want=1", bases_alive);
      end
      tick(0, 3'b010, 3);
      checks++;
      if ({screen, game_rst, playing, score} !== {2'd3, 1'b1, 1'b0, 8'd3}) begin
         errors++; $display("FAIL lose_entry scr=%0d grst=%b score=%0d want scr=3 grst=1 score=3", screen, game_rst, score);
      end
   endtask

   task automatic test_win();
      go_play();
      for (int k = 0; k < KW; k++) tick(0, 0, k);
      checks++;
      if (playing !== 1'b1) begin
         errors++; $display("FAIL below_kills got=%b want=1", playing);
      end
      tick(0, 0, KW);
      checks++;
      if ({screen, score} !== {2'd2, 8'd5}) begin
         errors++; $display("FAIL win_entry scr=%0d score=%0d want scr=2 score=5", screen, score);
      end
      for (int j = 1; j <= 12; j++) begin
         tick((j == 3 || j == 10 || j == 12), 0, KW);
         checks++;
         if (j < 12 && screen !== 2'd2) begin
            errors++; $display("FAIL win_hold j=%0d scr=%0d want=2", j, screen);
         end else if (j == 12 && {screen, game_rst} !== 3'b001) begin
            errors++; $display("FAIL win_exit scr=%0d grst=%b want scr=0 grst=1", screen, game_rst);
         end
      end
      repeat (CC) tick(0, 0, 0);
      checks++;
      if ({playing, bases_alive, score} !== {1'b1, 2'd3, 8'd5}) begin
         errors++; $display("FAIL replay pl=%b bases=%0d score=%0d want pl=1 bases=3 score=5", playing, bases_alive, score);
      end
   endtask

   task automatic test_tie();
      go_play();
      tick(0, 3'b001, 0);
      tick(0, 3'b010, 0);
      checks++;
      if (bases_alive !== 2'd1) begin
         errors++; $display("FAIL tie_bases got=%0d want=1", bases_alive);
      end
      tick(0, 3'b100, KW);
      checks++;
      if ({screen, score} !== {2'd3, 8'd5}) begin
         errors++; $display("FAIL tie_lose scr=%0d score=%0d want scr=3 score=5", screen, score);
      end
   endtask

   task automatic test_async_reset();
      // Leave the LOSE screen from test_tie into CLEAR with score still 5.
      repeat (ET + 1) tick(0, 0, 0);
      tick(1, 0, 0);
      checks++;
      if ({screen, game_rst, score} !== {2'd0, 1'b1, 8'd5}) begin
         errors++; $display("FAIL pre_rst_clear scr=%0d grst=%b score=%0d want 0/1/5", screen, game_rst, score);
      end
      tick(0, 0, 0);
      #2 rst = 1;
      #1;
      checks++;
      if (obs() !== {1'b1, 1'b0, 2'd0, 2'd3, 8'd0, 1'b0}) begin
         errors++; $display("FAIL async_rst_clear got=%h want=%h", obs(), {1'b1, 1'b0, 2'd0, 2'd3, 8'd0, 1'b0});
      end
      model_reset();
      @(negedge clk) rst = 0;
      go_play();
      tick(0, 3'b001, 0);
      tick(0, 0, KW);
      checks++;
      if ({screen, bases_alive, score} !== {2'd2, 2'd2, 8'd5}) begin
         errors++; $display("FAIL pre_rst_win scr=%0d bases=%0d score=%0d want 2/2/5", screen, bases_alive, score);
      end
      tick(0, 0, KW);
      #2 rst = 1;
      #1;
      checks++;
      if (obs() !== {1'b1, 1'b0, 2'd0, 2'd3, 8'd0, 1'b0}) begin
         errors++; $display("FAIL async_rst_win got=%h want=%h", obs(), {1'b1, 1'b0, 2'd0, 2'd3, 8'd0, 1'b0});
      end
      model_reset();
      @(negedge clk) rst = 0;
   endtask

   task automatic test_random();
      bit c;
      bit [2:0] f;
      int k;
      int bad;
      do_reset();
      c = 0; bad = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 20) c = ~c;
         f[0] = ($urandom_range(0, 99) < 5);
         f[1] = ($urandom_range(0, 99) < 5);
         f[2] = ($urandom_range(0, 99) < 5);
         k = ($urandom_range(0, 99) < 2) ? $urandom_range(KW, 255) : $urandom_range(0, KW - 1);
         tick(c, f, k);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            if (bad < 10) $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), expv());
            bad++;
         end
      end
   endtask

   initial begin
      rst = 1; click = 0; b1 = 0; b2 = 0; b3 = 0; kc = '0;
      model_reset();
      test_reset();
      test_start();
      test_hold_click();
      test_lose();
      test_win();
      test_tie();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
